uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer between the UART receiver and the CPU/MMIO read port.
//  - Absorbs bursts from the receiver's Decoupled output so the CPU can read in batches.
//  - Exposes fill level and sticky error flags for the status register.
//  - Sits directly downstream of the UART receiver: takes its byte stream and its overrun pulse.

---
 rtl/uart_pkg.sv | 5 +
 rtl/veryl_Decoupled.sv | 9 +
 rtl/uart_fifo_mem.sv | 22 ++
 rtl/uart_rx_fifo.sv | 85 ++++++++
 tb/tb_uart_rx_fifo.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and byte type, used by the TX/RX blocks and the RX FIFO.
package uart_pkg;
  localparam int unsigned UART_DATA_WIDTH = 8;
  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;
endpackage

// File: rtl/veryl_Decoupled.sv
// Ready/valid byte channel; a transfer happens on any cycle with valid && ready.
interface veryl_Decoupled;
  import uart_pkg::*;
  logic       valid;
  logic       ready;
  uart_byte_t bits;
  modport sender   (output valid, output bits, input ready);
  modport receiver (input valid, input bits, output ready);
endinterface

// File: rtl/uart_fifo_mem.sv
// Unreset DEPTH x byte register array with one write port and one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  uart_byte_t       wdata,
  input  logic [PTR_W-1:0] raddr,
  output uart_byte_t       rdata
);
  uart_byte_t mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO between the UART receiver and the CPU read port,
// with fill level, almost-full and a sticky overrun flag for the status register.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned ALMOST_FULL_LVL = 12,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  veryl_Decoupled.receiver   if_din,
  input  logic               i_rx_overrun,
  veryl_Decoupled.sender     if_dout,
  input  logic               i_flush,
  input  logic               i_clear_err,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_almost_full,
  output logic               o_overrun_err
);
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             almost_full;
  logic             overrun_err;
  logic             push;
  logic             pop;
  uart_byte_t       rdata;

  // Handshake depends only on registered count, so a pop never frees a slot in the same cycle.
  assign if_din.ready  = (count != CNT_W'(DEPTH));
  assign if_dout.valid = (count != '0);
  assign if_dout.bits  = rdata;
  assign push          = if_din.valid && if_din.ready;
  assign pop           = if_dout.valid && if_dout.ready;

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .i_clk (i_clk),
    .we    (push && !i_flush),
    .waddr (wr_ptr),
    .wdata (if_din.bits),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_comb begin
    count_nxt = count;
    if (i_flush)           count_nxt = '0;
    else if (push && !pop) count_nxt = count + CNT_W'(1);
    else if (pop && !push) count_nxt = count - CNT_W'(1);
  end

  // Flush overrides any same-cycle push or pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_nxt;
      almost_full <= (count_nxt >= CNT_W'(ALMOST_FULL_LVL));
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Sticky overrun: a new overrun beats a simultaneous clear; flush leaves it alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)             overrun_err <= 1'b0;
    else if (i_rx_overrun) overrun_err <= 1'b1;
    else if (i_clear_err)  overrun_err <= 1'b0;
  end

  assign o_count       = count;
  assign o_almost_full = almost_full;
  assign o_overrun_err = overrun_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and random stimulus for uart_rx_fifo, checked against a queue-based model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_rx_overrun;
  logic       i_flush;
  logic       i_clear_err;
  logic [4:0] o_count;
  logic       o_almost_full;
  logic       o_overrun_err;

  veryl_Decoupled din_if ();
  veryl_Decoupled dout_if ();

  uart_rx_fifo #(.DEPTH(DEPTH), .ALMOST_FULL_LVL(AF)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .if_din        (din_if),
    .i_rx_overrun  (i_rx_overrun),
    .if_dout       (dout_if),
    .i_flush       (i_flush),
    .i_clear_err   (i_clear_err),
    .o_count       (o_count),
    .o_almost_full (o_almost_full),
    .o_overrun_err (o_overrun_err)
  );

  always #5 i_clk = ~i_clk;

  int   checks = 0;
  int   errors = 0;
  uart_byte_t q[$];
  logic m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model's current state.
  task automatic check_state(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"}, 32'(o_count), 32'(n));
    chk({tag, ":dout_valid"}, 32'(dout_if.valid), 32'(n != 0));
    chk({tag, ":din_ready"}, 32'(din_if.ready), 32'(n != DEPTH));
    chk({tag, ":almost_full"}, 32'(o_almost_full), 32'(n >= AF));
    chk({tag, ":overrun_err"}, 32'(o_overrun_err), 32'(m_err));
    if (n != 0) chk({tag, ":dout_bits"}, 32'(dout_if.bits), 32'(q[0]));
  endtask

  // One clock cycle: drive at negedge, check the popped byte before the edge, update model, recheck.
  task automatic step(input string tag, input logic v, input uart_byte_t b, input logic rdy,
                      input logic fl, input logic ovr, input logic clr);
    logic push, pop;
    @(negedge i_clk);
    din_if.valid = v;   din_if.bits = b;   dout_if.ready = rdy;
    i_flush = fl;       i_rx_overrun = ovr; i_clear_err = clr;
    push = v && (q.size() != DEPTH);
    pop  = rdy && (q.size() != 0);
    #1;
    chk({tag, ":pre_valid"}, 32'(dout_if.valid), 32'(q.size() != 0));
    if (pop) chk({tag, ":pop_bits"}, 32'(dout_if.bits), 32'(q[0]));
    @(posedge i_clk);
    #1;
    if (fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(b);
    end
    if (ovr) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1;
    din_if.valid = 1'b0; din_if.bits = '0; dout_if.ready = 1'b0;
    i_flush = 1'b0; i_rx_overrun = 1'b0; i_clear_err = 1'b0;
    #12;
    check_state("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Fill with reads stalled, try one more push while full, then drain.
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step("fill_full", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Single byte into an empty FIFO appears on the next cycle.
    step("latency", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    step("latency_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Steady-state streaming at count 5 across pointer wrap.
    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("stream", 1'b1, 8'h30 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);

    // Pop while full: push only lands on the following cycle.
    for (int i = 0; i < 11; i++) step("top_up", 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step("full_pop", 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step("full_pop_next", 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);

    // Sticky overrun flag, set-over-clear priority, then clear.
    step("ovr_set", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("ovr_hold");
    step("ovr_setclr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    step("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush at count 7 with a simultaneous push/pop; flag survives.
    step("ovr_set2", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step("pre7", 1'b1, 8'h90 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("post_flush");

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(9) < 7), 8'($urandom), ($urandom_range(9) < 5),
           ($urandom_range(39) == 0), ($urandom_range(19) == 0), ($urandom_range(9) == 0));

    // Asynchronous reset mid-stream, observed before any clock edge.
    for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step("pre_rst_ovr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge i_clk);
    din_if.valid = 1'b1; din_if.bits = 8'h77;
    i_rx_overrun = 1'b0; i_clear_err = 1'b0; i_flush = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    q.delete();
    m_err = 1'b0;
    check_state("async_rst");
    @(negedge i_clk);
    i_rst = 1'b0;
    din_if.valid = 1'b0;
    step("after_rst", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    step("after_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
